// File: rtl/if_id_fifo_pkg.sv
// Shared fetch-path types and constants for the IF/ID buffer.
package if_id_fifo_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    localparam logic [INST_W-1:0] NOP_INST_WORD = 32'h0000_0000;
    localparam logic              RSTN_ENABLE   = 1'b0;

    // One buffered fetch: issued address paired with the returned word.
    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_pair_t;

endpackage

// File: rtl/if_id_fifo_fetch_fifo.sv
// Power-of-two FIFO of fetch pairs with full-width occupancy and synchronous clear.
module fetch_fifo
    import if_id_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  fetch_pair_t                din,
    output fetch_pair_t                dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_pair_t        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Storage is not reset; only entries below count are ever presented.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap modulo DEPTH through natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/if_id_fifo.sv
// Fetch-to-decode buffer: pairs each accepted fetch with next-cycle memory data,
// queues the pairs, and back-pressures the PC stage by credit.
module if_id_fifo
    import if_id_fifo_pkg::*;
#(
    parameter int unsigned       DEPTH    = 2,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_WORD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INST_ADDR_W-1:0]     pc_i,
    input  logic                       inst_mem_en_i,
    input  logic [INST_W-1:0]          inst_i,
    input  logic                       stall_i,
    input  logic                       flush_i,
    output logic                       fetch_stall_o,
    output logic [INST_ADDR_W-1:0]     id_pc_o,
    output logic [INST_W-1:0]          id_inst_o,
    output logic                       id_valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                   pend_valid;
    logic [INST_ADDR_W-1:0] pend_pc;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic [CNT_W:0]         credit_used;
    fetch_pair_t            din;
    fetch_pair_t            dout;
    logic [CNT_W-1:0]       count;

    // Credit counts the in-flight request so memory data always has a free slot.
    always_comb begin
        credit_used   = {1'b0, count} + (CNT_W+1)'(pend_valid);
        fetch_stall_o = credit_used >= (CNT_W+1)'(DEPTH);
    end

    assign accept = inst_mem_en_i && !fetch_stall_o && !flush_i;
    assign push   = pend_valid && !flush_i;
    assign pop    = id_valid_o && !stall_i && !flush_i;

    always_comb begin
        din      = '0;
        din.pc   = pend_pc;
        din.inst = inst_i;
    end

    // Pending request: memory returns its word on the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else begin
            pend_valid <= accept;
            if (accept) begin
                pend_pc <= pc_i;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush_i),
        .din   (din),
        .dout  (dout),
        .count (count)
    );

    // Empty buffer presents a bubble rather than stale storage.
    always_comb begin
        id_valid_o = count != '0;
        id_pc_o    = '0;
        id_inst_o  = NOP_INST;
        if (id_valid_o) begin
            id_pc_o   = dout.pc;
            id_inst_o = dout.inst;
        end
    end

    assign count_o = count;

endmodule

// File: tb/tb_if_id_fifo.sv
// Self-checking bench for if_id_fifo against a queue-based reference model.
module tb_if_id_fifo;
    import if_id_fifo_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      pc_i;
    logic             inst_mem_en_i;
    logic [31:0]      inst_i;
    logic             stall_i;
    logic             flush_i;
    logic             fetch_stall_o;
    logic [31:0]      id_pc_o;
    logic [31:0]      id_inst_o;
    logic             id_valid_o;
    logic [CNT_W-1:0] count_o;

    int checks = 0;
    int errors = 0;

    fetch_pair_t q[$];
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] pc_next;
    logic [31:0] wrap_next;
    bit          wrap_on;

    if_id_fifo #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .inst_mem_en_i (inst_mem_en_i),
        .inst_i        (inst_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .fetch_stall_o (fetch_stall_o),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .id_valid_o    (id_valid_o),
        .count_o       (count_o)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: pc 0x0,0x4,0x8 -> 0x11,0x22,0x33.
    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return ((pc >> 2) + 32'd1) * 32'h11;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = q.size() != 0;
        chk("count", 32'(count_o), 32'(q.size()));
        chk("id_valid", 32'(id_valid_o), 32'(v));
        chk("id_pc", id_pc_o, v ? q[0].pc : 32'h0);
        chk("id_inst", id_inst_o, v ? q[0].inst : NOP);
        chk("fetch_stall", 32'(fetch_stall_o), 32'((q.size() + int'(m_pend)) >= int'(DEPTH)));
    endtask

    // One clock: check outputs, drive inputs, advance the reference model.
    task automatic cyc(input bit en, input bit st, input bit fl);
        bit          full_m;
        fetch_pair_t e;
        @(negedge clk);
        check_outputs();
        if (wrap_on && id_valid_o && !st && !fl && id_pc_o == wrap_next) begin
            wrap_next += 32'd4;
        end
        inst_i        = m_pend ? mem_word(m_pend_pc) : $urandom();
        inst_mem_en_i = en;
        pc_i          = pc_next;
        stall_i       = st;
        flush_i       = fl;
        full_m        = (q.size() + int'(m_pend)) >= int'(DEPTH);
        if (fl) begin
            q.delete();
            m_pend = 1'b0;
        end else begin
            if (q.size() != 0 && !st) begin
                void'(q.pop_front());
            end
            if (m_pend) begin
                e.pc   = m_pend_pc;
                e.inst = inst_i;
                q.push_back(e);
            end
            if (en && !full_m) begin
                m_pend    = 1'b1;
                m_pend_pc = pc_next;
                pc_next   += 32'd4;
            end else begin
                m_pend = 1'b0;
            end
        end
    endtask

    // Asynchronous reset mid-stream: outputs must clear before the next edge.
    task automatic reset_mid(input int n);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(count_o), 32'h0);
        chk("rst_valid", 32'(id_valid_o), 32'h0);
        chk("rst_pc", id_pc_o, 32'h0);
        chk("rst_inst", id_inst_o, NOP);
        chk("rst_fetch_stall", 32'(fetch_stall_o), 32'h0);
        q.delete();
        m_pend        = 1'b0;
        inst_mem_en_i = 1'b0;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int guard;
        rst           = 1'b0;
        pc_i          = '0;
        inst_mem_en_i = 1'b0;
        inst_i        = '0;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        m_pend        = 1'b0;
        m_pend_pc     = '0;
        pc_next       = '0;
        wrap_next     = '0;
        wrap_on       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b1;

        // Streaming: pc 0,4,8 back to back
        pc_next = 32'h0;
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);

        // Back-pressure: 4-cycle stall in a stream
        pc_next = 32'h200;
        repeat (2) cyc(1'b1, 1'b0, 1'b0);
        repeat (4) cyc(1'b1, 1'b1, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);

        // Flush with buffered and pending fetches, while stalled
        pc_next = 32'h80;
        repeat (2) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        pc_next = 32'h40;
        cyc(1'b1, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);

        // Flush with a full buffer
        pc_next = 32'h500;
        repeat (4) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);

        // Stall toggling every cycle: simultaneous push/pop
        pc_next = 32'h300;
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'(i % 2), 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);

        // Wrap-around: ten fetches 0x100..0x124 under random stall
        pc_next   = 32'h100;
        wrap_next = 32'h100;
        wrap_on   = 1'b1;
        guard     = 0;
        while (pc_next != 32'h128 && guard < 200) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            guard++;
        end
        repeat (6) cyc(1'b0, 1'b0, 1'b0);
        wrap_on = 1'b0;
        chk("wrap_delivered", wrap_next, 32'h128);

        // Randomized traffic with occasional flush and a mid-stream reset
        pc_next = 32'h1000;
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                repeat (2) cyc(1'b1, 1'b1, 1'b0);
                reset_mid(3);
            end
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 15) == 0));
        end
        repeat (4) cyc(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
